// File: rtl/raytracing_line_writer_pkg.sv
// raytracing_line_writer_pkg: shared raytracer types, frame geometry and line writer FSM states
package raytracing_line_writer_pkg;
   localparam int N_WORKERS = 10;
   localparam int JOBS_SUBDIVISION = 64;
   localparam int LINE_WIDTH = 640;
   localparam int JOBS = LINE_WIDTH;
   localparam int LINES = 480;
   localparam int FB_ADDR_B = 19;
   localparam int Y_B = 9;
   localparam int W_B = $clog2(N_WORKERS);
   localparam int J_B = $clog2(JOBS_SUBDIVISION);
   typedef logic [23:0] Color;
   localparam Color BACKGROUND_COLOR = '0;
   typedef enum logic [2:0] {IDLE, WAIT_START, WAIT_DONE, COPY, DONE} line_state_t;
   // Constant multiply; synthesis reduces it to a shift-add.
   function automatic logic [FB_ADDR_B-1:0] line_base(logic [Y_B-1:0] y);
      return FB_ADDR_B'(y) * FB_ADDR_B'(LINE_WIDTH);
   endfunction
endpackage

// File: rtl/raytracing_line_writer_if.sv
// raytracing_line_writer_if: framebuffer write port with ready backpressure
interface raytracing_line_writer_if;
   import raytracing_line_writer_pkg::*;
   logic fb_we;
   logic [FB_ADDR_B-1:0] fb_addr;
   Color fb_data;
   logic fb_ready;
   modport master(output fb_we, fb_addr, fb_data, input fb_ready);
   modport slave(input fb_we, fb_addr, fb_data, output fb_ready);
endinterface

// File: rtl/raytracing_column_counter.sv
// raytracing_column_counter: walks worker/slot/address in raster order without divide or modulo
module raytracing_column_counter import raytracing_line_writer_pkg::*; (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic [FB_ADDR_B-1:0] base,
   input  logic advance,
   output logic [W_B-1:0] w,
   output logic [J_B-1:0] j,
   output logic [FB_ADDR_B-1:0] addr,
   output logic last
);
   logic w_wrap;
   assign w_wrap = w == W_B'(N_WORKERS - 1);
   assign last = w_wrap && j == J_B'(JOBS_SUBDIVISION - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         w <= '0;
         j <= '0;
         addr <= '0;
      end else if (load) begin
         w <= '0;
         j <= '0;
         addr <= base;
      end else if (advance) begin
         w <= w_wrap ? '0 : w + 1'b1;
         j <= w_wrap ? j + 1'b1 : j;
         addr <= addr + 1'b1;
      end
   end
endmodule

// File: rtl/raytracing_line_writer.sv
// raytracing_line_writer: de-interleaves worker buffers and streams one scanline to the framebuffer
module raytracing_line_writer import raytracing_line_writer_pkg::*; (
   input  logic clk,
   input  logic rst,
   input  logic line_start,
   input  logic [Y_B-1:0] line_y,
   input  logic [N_WORKERS-1:0] workers_busy,
   input  Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0] worker_buffers,
   raytracing_line_writer_if.master fb,
   output logic line_done,
   output logic frame_done,
   output logic overrun
);
   line_state_t state, state_nx;
   logic [Y_B-1:0] y_q;
   logic [W_B-1:0] w;
   logic [J_B-1:0] j;
   logic [FB_ADDR_B-1:0] addr;
   logic last, take, advance, tail;
   // tail: column 639 already sits in the output register, stop fetching.
   assign take = state == COPY && (!fb.fb_we || fb.fb_ready);
   assign advance = take && !tail;
   assign line_done = state == DONE;
   assign frame_done = line_done && y_q == Y_B'(LINES - 1);
   raytracing_column_counter u_cnt (
      .clk(clk),
      .rst(rst),
      .load(state == IDLE && line_start),
      .base(line_base(line_y)),
      .advance(advance),
      .w(w),
      .j(j),
      .addr(addr),
      .last(last)
   );
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:       state_nx = line_start ? WAIT_START : IDLE;
         WAIT_START: state_nx = |workers_busy ? WAIT_DONE : WAIT_START;
         WAIT_DONE:  state_nx = workers_busy == '0 ? COPY : WAIT_DONE;
         COPY:       state_nx = tail && fb.fb_we && fb.fb_ready ? DONE : COPY;
         DONE:       state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         fb.fb_we <= 1'b0;
         fb.fb_addr <= '0;
         fb.fb_data <= '0;
         y_q <= '0;
         tail <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= overrun | (line_start && state != IDLE);
         if (state == IDLE && line_start) y_q <= line_y;
         tail <= state == COPY && (tail | (advance && last));
         if (take) begin
            fb.fb_we <= !tail;
            if (!tail) begin
               fb.fb_addr <= addr;
               fb.fb_data <= worker_buffers[w][j];
            end
         end
      end
   end
endmodule

// File: tb/tb_raytracing_line_writer.sv
// tb_raytracing_line_writer: scoreboard bench for the scanline writer
module tb_raytracing_line_writer;
   import raytracing_line_writer_pkg::*;
   typedef struct packed {
      logic [FB_ADDR_B-1:0] a;
      Color d;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic line_start = 1'b0;
   logic [Y_B-1:0] line_y = '0;
   logic [N_WORKERS-1:0] workers_busy = '0;
   Color [N_WORKERS-1:0][JOBS_SUBDIVISION-1:0] wb;
   logic line_done, frame_done, overrun;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int stalls = 0;
   int acc_cyc = -1;
   int done_cyc = -1;
   int cur_y = 0;
   int u;
   exp_t q[$];
   exp_t e;
   logic prev_stall = 1'b0;
   logic [FB_ADDR_B-1:0] prev_addr;
   Color prev_data;
   raytracing_line_writer_if fb();
   raytracing_line_writer dut (
      .clk(clk),
      .rst(rst),
      .line_start(line_start),
      .line_y(line_y),
      .workers_busy(workers_busy),
      .worker_buffers(wb),
      .fb(fb),
      .line_done(line_done),
      .frame_done(frame_done),
      .overrun(overrun)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Scoreboard: every accepted write must match the head of the queue.
   always @(negedge clk) begin
      if (rst) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            checks++;
            assert (fb.fb_we === 1'b1 && fb.fb_addr === prev_addr && fb.fb_data === prev_data) else begin
               errors++;
               $error("FAIL stall_hold we=%b addr=%0d data=%h required we=1 addr=%0d data=%h", fb.fb_we, fb.fb_addr, fb.fb_data, prev_addr, prev_data);
            end
         end
         if (fb.fb_we && fb.fb_ready) begin
            checks++;
            assert (q.size() != 0) else begin
               errors++;
               $error("FAIL extra_write addr=%0d data=%h required no write", fb.fb_addr, fb.fb_data);
            end
            if (q.size() != 0) begin
               e = q.pop_front();
               checks++;
               assert (fb.fb_addr === e.a && fb.fb_data === e.d) else begin
                  errors++;
                  $error("FAIL pixel addr=%0d data=%h required addr=%0d data=%h", fb.fb_addr, fb.fb_data, e.a, e.d);
               end
               acc_cyc = cyc;
            end
         end
         if (fb.fb_we && !fb.fb_ready) stalls++;
         prev_stall = fb.fb_we && !fb.fb_ready;
         prev_addr = fb.fb_addr;
         prev_data = fb.fb_data;
         if (line_done || frame_done) begin
            checks++;
            assert (line_done === 1'b1 && frame_done === (cur_y == LINES - 1) && acc_cyc == cyc - 1 && q.size() == 0) else begin
               errors++;
               $error("FAIL done_pulse line_done=%b frame_done=%b last_accept=%0d left=%0d required 1/%b/%0d/0", line_done, frame_done, acc_cyc, q.size(), cur_y == LINES - 1, cyc - 1);
            end
            done_cyc = cyc;
         end
      end
   end
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s got=%0d required=%0d", tag, got, want);
      end
   endtask
   task automatic start_line(input int y);
      cur_y = y;
      for (int k = 0; k < LINE_WIDTH; k++) begin
         exp_t x;
         logic [3:0] wv;
         logic [7:0] jv;
         wv = 4'(k % N_WORKERS);
         jv = 8'(k / N_WORKERS);
         x.a = FB_ADDR_B'(y * LINE_WIDTH + k);
         x.d = Color'({wv, jv});
         q.push_back(x);
      end
      stalls = 0;
      done_cyc = -1;
      line_start = 1'b1;
      line_y = Y_B'(y);
      step;
      line_start = 1'b0;
      check("wait_start_we", 32'(fb.fb_we), 0);
   endtask
   task automatic run_busy(input bit stagger, input bit ovr, output int uo);
      workers_busy = '1;
      repeat (3) step;
      if (ovr) begin
         line_start = 1'b1;
         line_y = 9'd100;
         step;
         line_start = 1'b0;
         check("overrun_set", 32'(overrun), 1);
      end
      for (int i = 0; i < N_WORKERS; i++) begin
         workers_busy[i] = 1'b0;
         if (stagger && i != N_WORKERS - 1)
            repeat (i % 3 + 1) begin
               step;
               check("early_we", 32'(fb.fb_we), 0);
            end
      end
      uo = cyc;
      step;
      check("we_at_u1", 32'(fb.fb_we), 0);
      step;
      check("we_at_u2", 32'(fb.fb_we), 1);
      check("first_addr", 32'(fb.fb_addr), 32'(cur_y * LINE_WIDTH));
   endtask
   task automatic finish_line(input int uo, input bit rnd);
      for (int n = 0; n < 4000 && done_cyc < 0; n++) begin
         step;
         if (rnd) fb.fb_ready = 1'($urandom_range(0, 1));
      end
      fb.fb_ready = 1'b1;
      check("line_done_seen", 32'(done_cyc >= 0), 1);
      check("line_length", 32'(done_cyc), 32'(uo + 642 + stalls));
      step;
      check("done_one_cycle", 32'(line_done), 0);
   endtask
   initial begin
      for (int w = 0; w < N_WORKERS; w++)
         for (int j = 0; j < JOBS_SUBDIVISION; j++)
            wb[w][j] = Color'({4'(w), 8'(j)});
      fb.fb_ready = 1'b1;
      repeat (2) step;
      rst = 1'b0;
      check("rst_we", 32'(fb.fb_we), 0);
      check("rst_addr", 32'(fb.fb_addr), 0);
      check("rst_data", 32'(fb.fb_data), 0);
      check("rst_line_done", 32'(line_done), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_overrun", 32'(overrun), 0);
      // Abandon line 2 at column 300.
      start_line(2);
      run_busy(1'b0, 1'b0, u);
      for (int n = 0; n < 1000; n++) begin
         if (fb.fb_we && fb.fb_addr == FB_ADDR_B'(2 * LINE_WIDTH + 300)) break;
         step;
      end
      check("reached_col300", 32'(fb.fb_addr), 32'(2 * LINE_WIDTH + 300));
      rst = 1'b1;
      step;
      rst = 1'b0;
      q.delete();
      check("mid_rst_we", 32'(fb.fb_we), 0);
      check("mid_rst_addr", 32'(fb.fb_addr), 0);
      check("mid_rst_data", 32'(fb.fb_data), 0);
      check("mid_rst_overrun", 32'(overrun), 0);
      repeat (5) begin
         step;
         check("no_done_after_rst", 32'({line_done, fb.fb_we}), 0);
      end
      start_line(0);
      run_busy(1'b0, 1'b0, u);
      finish_line(u, 1'b0);
      start_line(LINES - 1);
      run_busy(1'b0, 1'b0, u);
      finish_line(u, 1'b0);
      start_line(5);
      run_busy(1'b0, 1'b0, u);
      finish_line(u, 1'b1);
      check("stalls_seen", 32'(stalls > 0), 1);
      start_line(7);
      run_busy(1'b1, 1'b0, u);
      finish_line(u, 1'b0);
      check("overrun_clear", 32'(overrun), 0);
      start_line(9);
      run_busy(1'b0, 1'b1, u);
      finish_line(u, 1'b0);
      repeat (3) step;
      check("overrun_sticky", 32'(overrun), 1);
      check("no_second_line", 32'(fb.fb_we), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
